// File: rtl/wb_fair_memory.sv
// Wishbone classic slave: word RAM with bounded pseudo-random wait states and a
// periodic interrupt source. Ack is a registered single-cycle pulse 1..MAX_WAIT cycles after accept.
module wb_fair_memory #(
  parameter int          DEPTH_LOG2  = 10,
  parameter int          MIN_WAIT    = 1,
  parameter int          MAX_WAIT    = 3,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1,
  parameter int unsigned IRQ_PERIOD  = 0,
  parameter logic [29:0] IRQ_ACK_ADR = 30'h3FFFFFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [29:0] bus__adr,
  input  logic        bus__cyc,
  input  logic        bus__stb,
  input  logic [3:0]  bus__sel,
  input  logic        bus__we,
  input  logic [31:0] bus__dat_w,
  output logic [31:0] bus__dat_r,
  output logic        bus__ack,
  output logic        irq
);
  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

  typedef struct packed {
    logic [29:0] adr;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] dat;
  } req_t;

  state_t      state, state_nx;
  logic [2:0]  cnt, cnt_nx;
  logic [15:0] lfsr;
  logic [4:0]  wsum;
  logic [2:0]  wsel;
  req_t        req;
  logic [31:0] irq_cnt;
  logic        accept, irq_hit, irq_clr;
  logic [DEPTH_LOG2-1:0] idx;
  logic [31:0] mem [DEPTH] = '{default: 32'h0};

  assign accept  = (state == IDLE) && bus__cyc && bus__stb;
  assign wsum    = 5'(MIN_WAIT) + {1'b0, lfsr[3:0]};
  assign wsel    = (wsum > 5'(MAX_WAIT)) ? 3'(MAX_WAIT) : wsum[2:0];
  assign idx     = req.adr[DEPTH_LOG2-1:0];
  assign irq_hit = (req.adr == IRQ_ACK_ADR);
  assign irq_clr = (state == ACK) && req.we && irq_hit && req.sel[0];

  // cnt counts the cycles still to go before ACK; a latency of 1 skips WAIT
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      IDLE: if (bus__cyc && bus__stb) begin
        cnt_nx   = wsel - 3'd1;
        state_nx = (wsel == 3'd1) ? ACK : WAIT;
      end
      WAIT: begin
        if (!bus__cyc)        state_nx = IDLE;
        else if (cnt == 3'd1) state_nx = ACK;
        else                  cnt_nx   = cnt - 3'd1;
      end
      ACK:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 3'd0;
      lfsr  <= LFSR_SEED;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      lfsr  <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
  end

  always_ff @(posedge clk) begin
    if (accept) req <= '{adr: bus__adr, we: bus__we, sel: bus__sel, dat: bus__dat_w};
  end

  // The irq register address shadows its RAM alias
  always_ff @(posedge clk) begin
    if (!rst && state == ACK && req.we && !irq_hit) begin
      for (int b = 0; b < 4; b++)
        if (req.sel[b]) mem[idx][8*b +: 8] <= req.dat[8*b +: 8];
    end
  end

  // irq rises on the edge where the counter steps 1 -> 0; a clear beats expiry
  always_ff @(posedge clk) begin
    if (rst) begin
      irq     <= 1'b0;
      irq_cnt <= 32'(IRQ_PERIOD);
    end else if (irq_clr) begin
      irq     <= 1'b0;
      irq_cnt <= 32'(IRQ_PERIOD);
    end else if (IRQ_PERIOD != 0 && !irq) begin
      if (irq_cnt == 32'd1) irq <= 1'b1;
      irq_cnt <= irq_cnt - 32'd1;
    end
  end

  assign bus__ack   = (state == ACK);
  assign bus__dat_r = (state != ACK) ? 32'h0 :
                      irq_hit        ? {31'b0, irq} : mem[idx];
endmodule
